// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART register-access master.
// Optional RX response timeout is enabled by defining UART_RX_TIMEOUT_EN.
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_TX_START = 4'd1,
    ST_TX_DATA  = 4'd2,
    ST_TX_PAR   = 4'd3,
    ST_TX_STOP  = 4'd4,
    ST_TX_GAP   = 4'd5,
    ST_RX_WAIT  = 4'd6,
    ST_RX_START = 4'd7,
    ST_RX_DATA  = 4'd8,
    ST_RX_PAR   = 4'd9,
    ST_RX_STOP  = 4'd10,
    ST_DONE     = 4'd11
  } state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    case (mode)
      PARITY_EVEN: p = ^data;
      PARITY_ODD:  p = ~(^data);
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

  // Byte counts for a full write command, the read request and the read response.
  function automatic int cmd_bytes(input int addr_w, input int data_w);
    return (1 + addr_w + data_w) / 8;
  endfunction

  function automatic int addr_bytes(input int addr_w);
    return (1 + addr_w) / 8;
  endfunction

  function automatic int data_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter shared by the TX and RX phases; strobes at mid-bit and end-of-bit.
module uart_bit_timer #(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick_mid,
  output logic tick_end
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_r;

  // Counts 0..CLK_DIV-1 while running; clear restarts the bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (run) begin
      if (cnt_r == CNT_W'(CLK_DIV - 1)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick_mid = run && (cnt_r == CNT_W'(CLK_DIV / 2 - 1));
  assign tick_end = run && (cnt_r == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/uart_reg_master.sv
// UART register-access master: serialises {rw, addr, wdata}, collects read responses.
// Define UART_RX_TIMEOUT_EN to bound the wait for each response start bit.
module uart_reg_master #(
  parameter int CLK_DIV    = 434,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 1,
  parameter int GAP_BITS   = 2,
  parameter int RX_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W+DATA_W:0]   cmd_in,
  input  logic                     cmd_vld,
  output logic                     cmd_rdy,
  input  logic                     rx,
  output logic                     tx,
  output logic                     read_vld,
  output logic [DATA_W-1:0]        read_data,
  output logic                     read_err
);
  import uart_pkg::*;

  localparam int CMD_W    = 1 + ADDR_W + DATA_W;
  localparam int WR_BYTES = cmd_bytes(ADDR_W, DATA_W);
  localparam int RQ_BYTES = addr_bytes(ADDR_W);
  localparam int RX_BYTES = data_bytes(DATA_W);
  localparam int BC_W     = $clog2(WR_BYTES);
  localparam int BIT_W    = $clog2((GAP_BITS > 8) ? GAP_BITS : 8);
  localparam int TO_W     = $clog2(RX_TIMEOUT + 1);
`ifdef UART_RX_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_e            state_r, state_s, after_tx_s;
  logic              tick_mid_s, tick_end_s, timer_run_s, timer_clr_s;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [BC_W-1:0]   byte_cnt_r;
  logic [CMD_W-1:0]  tx_sh_r;
  logic [7:0]        cur_byte_s, rx_sh_r;
  logic [DATA_W-1:0] rx_buf_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              rw_r, err_r, tx_s, tx_r, cmd_rdy_r, read_vld_r, read_err_r;
  logic [DATA_W-1:0] read_data_r;
  logic              rx_meta_r, rx_sync_r, rx_prev_r;
  logic              last_bit_s, last_gap_s, tx_last_s, rx_last_s, rx_fall_s, timeout_s;
  logic              accept_s, tx_byte_done_s;

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (timer_run_s),
    .clr      (timer_clr_s),
    .tick_mid (tick_mid_s),
    .tick_end (tick_end_s)
  );

  assign accept_s   = (state_r == ST_IDLE) && cmd_vld;
  assign cur_byte_s = tx_sh_r[CMD_W-1 -: 8];
  assign last_bit_s = (bit_cnt_r == BIT_W'(7));
  assign last_gap_s = (bit_cnt_r == BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0));
  assign tx_last_s  = (byte_cnt_r == (rw_r ? BC_W'(WR_BYTES - 1) : BC_W'(RQ_BYTES - 1)));
  assign rx_last_s  = (byte_cnt_r == BC_W'(RX_BYTES - 1));
  assign rx_fall_s  = rx_prev_r && !rx_sync_r;
  assign after_tx_s = !tx_last_s ? ST_TX_START : (rw_r ? ST_DONE : ST_RX_WAIT);
  assign timeout_s  = TIMEOUT_EN && (state_r == ST_RX_WAIT) && tick_end_s &&
                      (to_cnt_r == TO_W'(RX_TIMEOUT - 1));
  assign tx_byte_done_s = ((state_r == ST_TX_GAP) || ((state_r == ST_TX_STOP) && (GAP_BITS == 0)))
                          && (state_s != state_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:     if (cmd_vld) state_s = ST_TX_START; else state_s = ST_IDLE;
      ST_TX_START: if (tick_end_s) state_s = ST_TX_DATA; else state_s = ST_TX_START;
      ST_TX_DATA:
        if (tick_end_s && last_bit_s) state_s = (PARITY != PARITY_NONE) ? ST_TX_PAR : ST_TX_STOP;
        else state_s = ST_TX_DATA;
      ST_TX_PAR:   if (tick_end_s) state_s = ST_TX_STOP; else state_s = ST_TX_PAR;
      ST_TX_STOP:  if (tick_end_s) state_s = (GAP_BITS > 0) ? ST_TX_GAP : after_tx_s;
                   else state_s = ST_TX_STOP;
      ST_TX_GAP:   if (tick_end_s && last_gap_s) state_s = after_tx_s; else state_s = ST_TX_GAP;
      ST_RX_WAIT:
        if (timeout_s) state_s = ST_DONE;
        else if (rx_fall_s) state_s = ST_RX_START;
        else state_s = ST_RX_WAIT;
      // A start bit that is high again at mid-bit was a glitch.
      ST_RX_START:
        if (tick_mid_s) state_s = rx_sync_r ? ST_RX_WAIT : ST_RX_DATA;
        else state_s = ST_RX_START;
      ST_RX_DATA:
        if (tick_end_s && last_bit_s) state_s = (PARITY != PARITY_NONE) ? ST_RX_PAR : ST_RX_STOP;
        else state_s = ST_RX_DATA;
      ST_RX_PAR:   if (tick_end_s) state_s = ST_RX_STOP; else state_s = ST_RX_PAR;
      ST_RX_STOP:
        if (tick_end_s) state_s = rx_last_s ? ST_DONE : ST_RX_WAIT;
        else state_s = ST_RX_STOP;
      ST_DONE:     state_s = ST_IDLE;
      default:     state_s = ST_IDLE;
    endcase
  end

  // Output and timer-control decode; every state change restarts the bit period.
  always_comb begin
    tx_s        = 1'b1;
    timer_run_s = (state_r != ST_IDLE) && (state_r != ST_DONE);
    timer_clr_s = (state_s != state_r);
    case (state_r)
      ST_TX_START: tx_s = 1'b0;
      ST_TX_DATA:  tx_s = cur_byte_s[bit_cnt_r[2:0]];
      ST_TX_PAR:   tx_s = parity_bit(cur_byte_s, PARITY);
      default:     tx_s = 1'b1;
    endcase
  end

  // rx synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Command buffer, bit/byte counters, receive shifter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh_r    <= '0;
      rw_r       <= 1'b0;
      bit_cnt_r  <= '0;
      byte_cnt_r <= '0;
      rx_sh_r    <= '0;
      rx_buf_r   <= '0;
      err_r      <= 1'b0;
    end else if (accept_s) begin
      tx_sh_r    <= cmd_in;
      rw_r       <= cmd_in[CMD_W-1];
      bit_cnt_r  <= '0;
      byte_cnt_r <= '0;
      rx_buf_r   <= '0;
      err_r      <= 1'b0;
    end else begin
      if (state_s != state_r) begin
        bit_cnt_r <= '0;
      end else if (tick_end_s && ((state_r == ST_TX_DATA) || (state_r == ST_TX_GAP) ||
                                  (state_r == ST_RX_DATA))) begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (tx_byte_done_s) begin
        tx_sh_r    <= tx_sh_r << 8;
        byte_cnt_r <= tx_last_s ? '0 : byte_cnt_r + BC_W'(1);
      end else if ((state_r == ST_RX_STOP) && tick_end_s) begin
        byte_cnt_r <= byte_cnt_r + BC_W'(1);
        for (int i = 0; i < RX_BYTES; i++) begin
          if (byte_cnt_r == BC_W'(i)) rx_buf_r[DATA_W-1-8*i -: 8] <= rx_sh_r;
        end
      end else begin
        byte_cnt_r <= byte_cnt_r;
      end
      if ((state_r == ST_RX_DATA) && tick_end_s) begin
        rx_sh_r <= {rx_sync_r, rx_sh_r[7:1]};
      end else begin
        rx_sh_r <= rx_sh_r;
      end
      if (((state_r == ST_RX_PAR) && tick_end_s && (rx_sync_r != parity_bit(rx_sh_r, PARITY))) ||
          ((state_r == ST_RX_STOP) && tick_end_s && !rx_sync_r) || timeout_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Bit periods spent waiting for a response start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (state_r != ST_RX_WAIT) begin
      to_cnt_r <= '0;
    end else if (tick_end_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Registered outputs; read_data holds until the next read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r        <= 1'b1;
      cmd_rdy_r   <= 1'b1;
      read_vld_r  <= 1'b0;
      read_data_r <= '0;
      read_err_r  <= 1'b0;
    end else begin
      tx_r       <= tx_s;
      cmd_rdy_r  <= (state_s == ST_IDLE);
      read_vld_r <= (state_r == ST_DONE) && !rw_r;
      if ((state_r == ST_DONE) && !rw_r) begin
        read_data_r <= rx_buf_r;
        read_err_r  <= err_r;
      end else begin
        read_data_r <= read_data_r;
        read_err_r  <= read_err_r;
      end
    end
  end

  assign tx        = tx_r;
  assign cmd_rdy   = cmd_rdy_r;
  assign read_vld  = read_vld_r;
  assign read_data = read_data_r;
  assign read_err  = read_err_r;

endmodule

// File: tb/tb_uart_reg_master.sv
// Self-checking bench for uart_reg_master (CLK_DIV=16, 7-bit addr, 8-bit data, even parity).
module tb_uart_reg_master;

  localparam int CDIV     = 16;
  localparam int FRAME_CY = (1 + 8 + 1 + 1 + 2) * CDIV;

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  resp;
    bit          flip;
    bit          stop_bad;
    bit          glitch;
    logic [7:0]  exp_data;
    bit          exp_err;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_in = '0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic        rx = 1'b1;
  logic        tx;
  logic        read_vld;
  logic [7:0]  read_data;
  logic        read_err;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int vld_cnt = 0;
  logic [7:0] last_rd = 8'h00;

  uart_reg_master #(
    .CLK_DIV(CDIV), .ADDR_W(7), .DATA_W(8), .PARITY(1), .GAP_BITS(2), .RX_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .rx(rx), .tx(tx), .read_vld(read_vld), .read_data(read_data), .read_err(read_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read_vld) vld_cnt <= vld_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic issue(input logic [15:0] c);
    int n = 0;
    @(negedge clk);
    while (cmd_rdy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("cmd_rdy_wait", cmd_rdy, 1);
    cmd_in = c; cmd_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic get_frame(output logic [7:0] b, output logic p, output logic s, output int t0);
    int n = 0;
    b = '0; p = 1'b0; s = 1'b0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 600) begin @(negedge clk); n++; end
    t0 = cyc;
    if (n >= 600) begin
      chk("frame_start", tx, 0);
      return;
    end
    repeat (CDIV / 2 - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin repeat (CDIV) @(negedge clk); b[i] = tx; end
    repeat (CDIV) @(negedge clk); p = tx;
    repeat (CDIV) @(negedge clk); s = tx;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("cmd_rdy_back", cmd_rdy, 1);
  endtask

  task automatic run_txn(input txn_t v);
    logic [7:0] b, eb, d;
    logic p, s, e, got;
    int t, tp, vb, nb;
    vb = vld_cnt; tp = 0; d = '0; e = 1'b0; got = 1'b0;
    nb = v.cmd[15] ? 2 : 1;
    issue(v.cmd);
    for (int k = 0; k < nb; k++) begin
      eb = (k == 0) ? v.cmd[15:8] : v.cmd[7:0];
      get_frame(b, p, s, t);
      chk("tx_byte", b, eb);
      chk("tx_parity", p, ^eb);
      chk("tx_stop", s, 1);
      if (k > 0) chk("tx_gap_spacing", t - tp, FRAME_CY);
      tp = t;
    end
    if (v.cmd[15]) begin
      wait_rdy();
      chk("wr_no_read_vld", vld_cnt - vb, 0);
      chk("rd_data_hold", read_data, v.exp_data);
    end else begin
      repeat (48) @(negedge clk);
      if (v.glitch) begin
        rx = 1'b0; repeat (3) @(negedge clk); rx = 1'b1;
        repeat (32) @(negedge clk);
      end
      rx = 1'b0; repeat (CDIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin rx = v.resp[i]; repeat (CDIV) @(negedge clk); end
      rx = (^v.resp) ^ v.flip; repeat (CDIV) @(negedge clk);
      rx = ~v.stop_bad;
      for (int i = 0; i < 60 && !got; i++) begin
        @(negedge clk);
        if (i == CDIV) rx = 1'b1;
        if (read_vld === 1'b1) begin got = 1'b1; d = read_data; e = read_err; end
      end
      rx = 1'b1;
      chk("rd_vld_seen", got, 1);
      chk("rd_data", d, v.exp_data);
      chk("rd_err", e, v.exp_err);
      @(negedge clk);
      chk("rd_vld_one_cycle", read_vld, 0);
      chk("rd_vld_count", vld_cnt - vb, 1);
      repeat (CDIV) @(negedge clk);
    end
  endtask

  txn_t vec[8];
  txn_t rv;

  initial begin
    logic [7:0] b;
    logic p, s, got;
    int t, t1, n, vb;

    vec[0] = '{16'h8A5C, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vec[1] = '{16'h1200, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
    vec[2] = '{16'h1200, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1};
    vec[3] = '{16'h3400, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1};
    vec[4] = '{16'hFF00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vec[5] = '{16'h7F00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0};
    vec[6] = '{16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vec[7] = '{16'h8001, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    #23 chk("rst_tx", tx, 1);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_read_vld", read_vld, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_read_err", read_err, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vec[i]);
    last_rd = 8'h00;

    // Random reads and writes against the frame-level model.
    for (int i = 0; i < 12; i++) begin
      rv.cmd      = 16'($urandom);
      rv.resp     = 8'($urandom);
      rv.flip     = ($urandom_range(0, 3) == 0);
      rv.stop_bad = ($urandom_range(0, 4) == 0);
      rv.glitch   = ($urandom_range(0, 2) == 0);
      if (rv.cmd[15]) begin
        rv.exp_data = last_rd;
        rv.exp_err  = 1'b0;
      end else begin
        rv.exp_data = rv.resp;
        rv.exp_err  = rv.flip | rv.stop_bad;
        last_rd     = rv.resp;
      end
      run_txn(rv);
    end

    // cmd_vld held high across a write: the second command waits for cmd_rdy.
    @(negedge clk);
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    cmd_in = 16'hC3A1; cmd_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_in = 16'h9E0F;
    chk("held_rdy_low", cmd_rdy, 0);
    get_frame(b, p, s, t);  chk("held_first_b0", b, 8'hC3);
    get_frame(b, p, s, t1); chk("held_first_b1", b, 8'hA1);
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("held_rdy_back", cmd_rdy, 1);
    @(negedge clk); cmd_vld = 1'b0;
    get_frame(b, p, s, t);  chk("held_second_b0", b, 8'h9E);
    get_frame(b, p, s, t1); chk("held_second_b1", b, 8'h0F);
    wait_rdy();

    // Unanswered read.
    vb = vld_cnt;
    issue(16'h5500);
    get_frame(b, p, s, t);
    chk("noresp_tx_byte", b, 8'h55);
    got = 1'b0; t1 = 0;
    for (int i = 0; i < 1400 && !got; i++) begin
      @(negedge clk);
      if (read_vld === 1'b1) begin got = 1'b1; t1 = cyc; chk("to_data", read_data, 0); chk("to_err", read_err, 1); end
    end
`ifdef UART_RX_TIMEOUT_EN
    chk("to_vld_seen", got, 1);
    chk("to_latency_ok", ((t1 - t) >= 1230) && ((t1 - t) <= 1234), 1);
    wait_rdy();
`else
    chk("wait_forever_no_vld", vld_cnt - vb, 0);
    chk("wait_forever_busy", cmd_rdy, 0);
    #3 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
`endif

    // Reset in the middle of a start bit.
    issue(16'hF0F0);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("pre_rst_tx_low", tx, 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_tx", tx, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_rdy", cmd_rdy, 1);
    chk("post_rst_read_data", read_data, 0);
    repeat (40) @(negedge clk);
    chk("post_rst_tx_idle", tx, 1);
    rv = '{16'h2A00, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};
    run_txn(rv);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_reg_master.md
Name: uart_reg_master

Overview:
- Parametrised UART register-access master; successor to the fixed 16-bit command FSM.
- Accepts one command word {rw, addr, wdata} over a valid/ready handshake.
- Write: serialises the whole command as bytes on tx.
- Read: serialises rw+addr bytes, then receives DATA_W/8 response bytes on rx and returns them with an error flag.

Parameters:
- CLK_DIV, 434: clocks per bit period; ≥8.
- ADDR_W, 7: address width; ADDR_W+1 must be a multiple of 8.
- DATA_W, 8: data width; must be a multiple of 8.
- PARITY, 1: 0 none, 1 even, 2 odd.
- GAP_BITS, 2: idle bit periods after every transmitted byte.
- RX_TIMEOUT, 64: bit periods to wait for each response start bit (used only with the macro).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_in  in  1+ADDR_W+DATA_W  {rw[MSB], addr, wdata}; rw=1 write, rw=0 read
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  block idle; command accepted when cmd_vld && cmd_rdy
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output, idle high
- read_vld  out  1  one-cycle pulse, read complete
- read_data  out  DATA_W  received data, MSB byte first
- read_err  out  1  qualifies read_vld; parity, framing or timeout error

Behaviour:
- Reset values: tx=1, cmd_rdy=1, read_vld=0, read_data=0, read_err=0. All state and counters clear. Reset mid-frame forces tx=1 immediately.
- On accept, cmd_in is latched into cmd_buf. cmd_rdy drops the next cycle. cmd_vld while busy is ignored.
- Frame format: start 0, 8 data bits LSB first, parity bit if PARITY≠0 (even: XOR of data; odd: inverted), 1 stop bit. Each bit lasts CLK_DIV clocks.
- Bytes are sent from the most significant byte of cmd_buf downward, each followed by GAP_BITS idle periods.
- Write: all (1+ADDR_W+DATA_W)/8 bytes are sent, then the block returns to IDLE.
- Read: (ADDR_W+1)/8 bytes are sent, then the block receives DATA_W/8 bytes.
- States: IDLE → TX_START → TX_DATA (bit_cnt 0..7) → TX_PAR (skipped if PARITY=0) → TX_STOP → TX_GAP.
  - From TX_GAP: next byte (TX_START), RX_WAIT (read with address sent), or DONE.
  - RX_WAIT → RX_START → RX_DATA → RX_PAR → RX_STOP → RX_WAIT (more bytes) or DONE.
  - DONE → IDLE in 1 cycle; cmd_rdy=1 in IDLE.
- rx path:
  - 2-flop synchroniser; falling edge in RX_WAIT starts a byte.
  - RX_START samples at CLK_DIV/2. If rx=1 there, the edge is a glitch: return to RX_WAIT, no error.
  - Data, parity and stop bits are sampled every CLK_DIV clocks after that point.
- Errors are sticky for the transaction:
  - parity mismatch → err;
  - stop sampled 0 → err, reception continues.
- Read completion: in DONE, read_vld pulses for 1 cycle with read_data and read_err. read_data holds until the next read completes. Writes never pulse read_vld.
- Baud counter counts 0..CLK_DIV-1 and wraps; byte_cnt width is clog2 of the byte count.

Optional Feature:
- Macro UART_RX_TIMEOUT_EN.
- Defined: RX_WAIT counts bit periods; reaching RX_TIMEOUT → DONE with read_err=1 and read_data holding the bytes received so far (remaining bytes 0).
- Undefined: RX_WAIT waits indefinitely; only reset exits.

Decomposition:
- Package uart_pkg:
  - state enum;
  - PARITY_NONE/EVEN/ODD constants;
  - function computing the parity bit;
  - localparams for command byte counts.
- Sub-module uart_bit_timer: baud counter with start/clear, mid-bit and end-of-bit strobes, shared by the TX and RX phases.

Test Plan (CLK_DIV=16, ADDR_W=7, DATA_W=8, PARITY=1, GAP_BITS=2):
- Write cmd_in=16'h8A5C → tx frames 0x8A (parity 1) then 0x5C (parity 0), 2-bit gaps; cmd_rdy returns high; no read_vld.
- Read cmd_in=16'h1200; bench answers 0x3C with parity 0 → tx frame 0x12; read_vld pulse, read_data=8'h3C, read_err=0.
- Read; bench answers 0x3C with parity 1 → read_vld, read_data=8'h3C, read_err=1.
- Read; response stop bit 0 → read_err=1. A 3-clock rx low glitch before the response is ignored.
- Macro defined, RX_TIMEOUT=64, no response → read_vld at 64 bit periods after RX_WAIT entry, read_err=1, read_data=0.
- cmd_vld held during a write → second command not accepted until cmd_rdy. rst_n low mid-frame → tx=1 at once, cmd_rdy=1 after release.
